// File: rtl/rom_sequencer.sv
// Address sequencer for a synchronous ROM: walks a programmable window with a fixed step,
// single-pass or looping, and tags each returned word with a latency-compensated Valid strobe.
module rom_sequencer #(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned STEP   = 1,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Mode,
    input  logic          Hold,
    input  logic          Stop,
    input  logic [AW-1:0] StartAddr,
    input  logic [AW-1:0] EndAddr,
    output logic [AW-1:0] Addr,
    input  logic [DW-1:0] RdData,
    output logic [DW-1:0] X,
    output logic          Valid,
    output logic          Busy,
    output logic          Done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // One extra bit so a full 2^AW window (STEP=1, End=Start-1) fits the count.
    localparam int unsigned CW     = AW + 1;
    localparam logic [AW-1:0] STEP_V = AW'(STEP);

    logic [1:0]        r_state;
    logic [AW-1:0]     r_addr;
    logic [AW-1:0]     r_start;
    logic [CW-1:0]     r_len;
    logic [CW-1:0]     r_rem;
    logic              r_mode;
    logic [RD_LAT-1:0] r_pipe;
    logic [DW-1:0]     r_x;
    logic              r_valid;

    logic [1:0]        w_state_nxt;
    logic [AW-1:0]     w_addr_nxt;
    logic [CW-1:0]     w_rem_nxt;
    logic [AW-1:0]     w_span;
    logic [CW-1:0]     w_len;
    logic              w_issue;
    logic              w_tok_out;

    assign w_span    = EndAddr - StartAddr;
    assign w_len     = {1'b0, w_span / STEP_V} + CW'(1);
    assign w_issue   = (r_state == RUN) && !Hold && !Stop;
    assign w_tok_out = r_pipe[RD_LAT-1];

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_rem_nxt   = r_rem;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt = RUN;
                    w_addr_nxt  = StartAddr;
                    w_rem_nxt   = w_len;
                end
            end
            RUN: begin
                if (Stop) begin
                    w_state_nxt = DRAIN;
                end else if (!Hold) begin
                    if (r_rem > CW'(1)) begin
                        w_addr_nxt = r_addr + STEP_V;
                        w_rem_nxt  = r_rem - CW'(1);
                    end else if (r_mode) begin
                        // Loop reload happens on the last issue itself, so no bubble.
                        w_addr_nxt = r_start;
                        w_rem_nxt  = r_len;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (r_pipe == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_start <= '0;
            r_len   <= '0;
            r_rem   <= '0;
            r_mode  <= 1'b0;
            r_pipe  <= '0;
            r_x     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_rem   <= w_rem_nxt;
            if (r_state == IDLE && Start) begin
                r_start <= StartAddr;
                r_len   <= w_len;
                r_mode  <= Mode;
            end
            r_pipe  <= (r_pipe << 1) | RD_LAT'(w_issue);
            r_valid <= w_tok_out;
            if (w_tok_out) begin
                r_x <= RdData;
            end
        end
    end

    assign Addr  = r_addr;
    assign X     = r_x;
    assign Valid = r_valid;
    assign Busy  = (r_state != IDLE);
    assign Done  = (r_state == DONE);

endmodule
